mv_avg_filter_v2_0: RTL and testbench
=====================================

// Module: mv_avg_filter_v2_0
// PURPOSE
//  Parametrised moving-average (boxcar) filter, successor to the fixed 8-tap averager on the ADC path.
//  Input width, maximum window depth and runtime window length are generalised.
//  The output carries a valid flag and a per-sample strobe.
//  Sits between the 14-bit ADC sample register and downstream control/DAC logic.
//  An internal prescaler sets the decimated sample rate.
// PARAMETERS
//  DATA_W       14  signed input/output sample width
//  LOG2_DEPTH   5   log2 of max window depth; buffer holds DEPTH=2**LOG2_DEPTH samples (32)
// PORTS
//  clk            in   1          system clock (100 MHz)
//  rstn           in   1          asynchronous, active-low reset
//  i32_prescaler  in   32         sample period minus 1, in clk cycles (0 = every clk)
//  i5_log2_len    in   5          runtime window length N=2**i5_log2_len; clamped to LOG2_DEPTH
//  is_data        in   DATA_W     signed input sample
//  os_data        out  DATA_W     signed filtered output
//  o_strobe       out  1          1-clk pulse when os_data updates
//  o_valid        out  1          high once window holds N real samples since last clear
// BEHAVIOUR
//  Reset: os_data=0, o_strobe=0, o_valid=0, acc=0, prescaler cnt=0, wr_ptr=0, state=CLEAR, len_q=clamp(i5_log2_len).
//  Prescaler:
//   - 32-bit cnt increments each clk.
//   - When cnt >= i32_prescaler: internal sample strobe s=1 and cnt<=0.
//   - Using >= means lowering the prescaler mid-count never wraps.
//  States:
//   - CLEAR: writes 0 to buf[wr_ptr], wr_ptr++ each clk, acc<=0, fill<=0, o_valid<=0.
//     Leaves to FILL after DEPTH clks, with wr_ptr back at 0. Strobes s are ignored.
//   - FILL: on s, accumulates as below and fill++. When fill reaches N-1 on an s, goes to RUN.
//   - RUN: on s, accumulates; o_valid=1.
//  Accumulate (FILL/RUN, on s):
//   - buf[wr_ptr]<=is_data; acc<=acc+is_data-buf[(wr_ptr-N) mod DEPTH]; wr_ptr++ (wraps at DEPTH).
//   - In FILL the subtracted entry is a cleared 0, so no special case is needed.
//   - Exception, N=1 (len 0): the subtracted entry is the previous sample, i.e. the 1-sample window.
//  Widths:
//   - acc signed DATA_W+LOG2_DEPTH bits; no overflow possible.
//   - avg = acc >>> len_q (arithmetic). Result always fits DATA_W; no saturation needed.
//  Output and latency:
//   - On the clk after the s edge: os_data<=avg, o_strobe<=1.
//   - Latency is 1 clk from sample capture to os_data update.
//   - o_valid rises with the first o_strobe after the Nth sample.
//  Length change:
//   - clamp(i5_log2_len) != len_q in FILL/RUN -> len_q<=new, go to CLEAR, o_valid<=0.
//   - os_data holds its last value until the next o_strobe.
//   - A change during CLEAR updates len_q and restarts the CLEAR sweep from wr_ptr=0.
//  Simultaneous events: a length change on the same clk as s wins; that sample is dropped.
//  Reset mid-operation: everything returns to reset values immediately (async); CLEAR restarts after rstn rises.
// CONFIGURATION
//  MVAVG_ROUND_EN
//   - Defined: avg=(acc + (len_q?2**(len_q-1):0)) >>> len_q, i.e. round half up (toward +inf).
//     Uses one extra acc guard bit.
//   - Undefined: plain arithmetic shift, i.e. floor. Default: undefined.
// TESTING
//  1. Fill time:
//     - Stimulus: rstn low 100ns, then is_data=1000, prescaler=500, len=3.
//     - Response: CLEAR takes 32 clks; o_strobe every 501 clks; os_data ramps 125,250..1000.
//     - o_valid rises at the 8th o_strobe.
//  2. Step response:
//     - Stimulus: after test 1, is_data steps to -1000.
//     - Response: os_data = 750,500,...,-1000 over 8 strobes; o_valid stays 1.
//  3. Runtime length change:
//     - Stimulus: in RUN, len 3->5.
//     - Response: o_valid falls next clk; 32-clk CLEAR; o_valid returns after 32 strobes.
//     - A strobe coincident with the change yields no o_strobe.
//  4. Prescaler=0, len=0:
//     - Response: o_strobe every clk; os_data equals is_data delayed by 2 clks.
//     - Separately, len=7 requested -> behaves as len=5.
//  5. Rounding, len=1, prescaler=0:
//     - Inputs 1,2 -> 2 with MVAVG_ROUND_EN, 1 without.
//     - Inputs -3,-2 -> -2 with, -3 without.
//  6. Reset mid-RUN:
//     - Stimulus: rstn pulsed low for 3 clks mid-prescaler count.
//     - Response: outputs 0 asynchronously; CLEAR sweep repeats; the fill sequence of test 1 repeats exactly.

Source files
------------

// File: rtl/mv_avg_filter_v2_0.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mv_avg_filter_v2_0 : prescaled moving-average filter, runtime window 2**len |
// | Optional macro MVAVG_ROUND_EN selects round-half-up output instead of floor.|
// | Rev 2.0                                                                     |
// +-----------------------------------------------------------------------------+
module mv_avg_filter_v2_0 #(
  parameter int DATA_W     = 14,
  parameter int LOG2_DEPTH = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [31:0]              i32_prescaler,
  input  logic [4:0]               i5_log2_len,
  input  logic signed [DATA_W-1:0] is_data,
  output logic signed [DATA_W-1:0] os_data,
  output logic                     o_strobe,
  output logic                     o_valid
);

  localparam int DEPTH = 2**LOG2_DEPTH;
  localparam int LEN_W = $clog2(LOG2_DEPTH + 1);
`ifdef MVAVG_ROUND_EN
  localparam int ACC_W = DATA_W + LOG2_DEPTH + 1;
`else
  localparam int ACC_W = DATA_W + LOG2_DEPTH;
`endif

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                  state;
  logic [31:0]             cnt;
  logic [LOG2_DEPTH-1:0]   wr_ptr;
  logic [LOG2_DEPTH-1:0]   fill;
  logic [LEN_W-1:0]        len_q;
  logic signed [ACC_W-1:0] acc;
  logic                    pend;
  logic signed [DATA_W-1:0] buf_mem [DEPTH];

  logic [LEN_W-1:0]         len_new;
  logic [LOG2_DEPTH-1:0]    n_low;
  logic [LOG2_DEPTH-1:0]    n_minus1;
  logic [LOG2_DEPTH-1:0]    rd_idx;
  logic signed [DATA_W-1:0] old_sample;
  logic signed [DATA_W-1:0] avg;
  logic signed [DATA_W-1:0] buf_wdata;
  logic                     samp_tick;
  logic                     len_chg;
  logic                     accept;
  logic                     buf_we;
`ifdef MVAVG_ROUND_EN
  logic signed [ACC_W-1:0]  rnd;
`endif

  always_comb begin
    if (i5_log2_len > 5'(LOG2_DEPTH)) len_new = LEN_W'(LOG2_DEPTH);
    else                              len_new = LEN_W'(i5_log2_len);
  end

  // n_low wraps to 0 for the full-depth window, which makes rd_idx == wr_ptr
  always_comb begin
    n_low      = LOG2_DEPTH'(1 << len_q);
    n_minus1   = n_low - LOG2_DEPTH'(1);
    rd_idx     = wr_ptr - n_low;
    old_sample = buf_mem[rd_idx];
    samp_tick  = (cnt >= i32_prescaler);
    len_chg    = (len_new != len_q);
    accept     = (state != ST_CLEAR) && samp_tick && !len_chg;
    buf_we     = (state == ST_CLEAR) || accept;
    buf_wdata  = (state == ST_CLEAR) ? '0 : is_data;
  end

`ifdef MVAVG_ROUND_EN
  always_comb begin
    rnd = '0;
    if (len_q != '0) rnd = ACC_W'(1) <<< (len_q - LEN_W'(1));
    avg = DATA_W'((acc + rnd) >>> len_q);
  end
`else
  always_comb begin
    avg = DATA_W'(acc >>> len_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[wr_ptr] <= buf_wdata;
  end

  // len_q tracks the requested length through reset so CLEAR starts with it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_CLEAR;
      cnt      <= '0;
      wr_ptr   <= '0;
      fill     <= '0;
      acc      <= '0;
      len_q    <= len_new;
      pend     <= 1'b0;
      os_data  <= '0;
      o_strobe <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      cnt      <= samp_tick ? 32'd0 : cnt + 32'd1;
      pend     <= accept;
      o_strobe <= pend;
      if (pend) begin
        os_data <= avg;
        o_valid <= (state == ST_RUN);
      end

      case (state)
        ST_CLEAR: begin
          acc     <= '0;
          fill    <= '0;
          o_valid <= 1'b0;
          if (len_chg) begin
            len_q  <= len_new;
            wr_ptr <= '0;
          end else begin
            wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
            if (wr_ptr == LOG2_DEPTH'(DEPTH - 1)) state <= ST_FILL;
          end
        end
        default: begin
          if (len_chg) begin
            len_q   <= len_new;
            state   <= ST_CLEAR;
            wr_ptr  <= '0;
            acc     <= '0;
            fill    <= '0;
            o_valid <= 1'b0;
          end else if (samp_tick) begin
            // during FILL the retired entry is a cleared zero
            acc    <= acc + ACC_W'(is_data) - ACC_W'(old_sample);
            wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
            if (state == ST_FILL) begin
              fill <= fill + LOG2_DEPTH'(1);
              if (fill == n_minus1) state <= ST_RUN;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mv_avg_filter_v2_0.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mv_avg_filter_v2_0 : directed bench with a queue-based reference model   |
// | Rev 2.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_mv_avg_filter_v2_0;

  localparam int DATA_W = 14;

  logic                     clk           = 1'b0;
  logic                     rstn          = 1'b0;
  logic [31:0]              i32_prescaler = 32'd500;
  logic [4:0]               i5_log2_len   = 5'd3;
  logic signed [DATA_W-1:0] is_data       = 14'sd1000;
  logic signed [DATA_W-1:0] os_data;
  logic                     o_strobe;
  logic                     o_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mv_avg_filter_v2_0 #(.DATA_W(DATA_W), .LOG2_DEPTH(5)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i32_prescaler (i32_prescaler),
    .i5_log2_len   (i5_log2_len),
    .is_data       (is_data),
    .os_data       (os_data),
    .o_strobe      (o_strobe),
    .o_valid       (o_valid)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the output is the average of the last N accepted samples,
  // with missing history counted as zero.
  longint m_cnt;
  int     m_clear, m_lenq, m_count, m_pend, m_pend_avg, m_pend_valid;
  int     m_q[$];
  int     exp_os, exp_strobe, exp_valid;
  bit     model_ok = 1'b0;

  function automatic int clamp_len(int l);
    return (l > 5) ? 5 : l;
  endfunction

  function automatic int floor_div(int sum, int n);
    int q;
    q = sum / n;
    if ((sum % n) != 0 && sum < 0) q--;
    return q;
  endfunction

  function automatic int window_avg();
    int n;
    int sum;
    n   = 1 << m_lenq;
    sum = 0;
    for (int i = 0; i < n && i < m_q.size(); i++) sum += m_q[m_q.size() - 1 - i];
`ifdef MVAVG_ROUND_EN
    sum += n / 2;
`endif
    return floor_div(sum, n);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt      = 0;
      m_clear    = 32;
      m_lenq     = clamp_len(int'(i5_log2_len));
      m_q.delete();
      m_count    = 0;
      m_pend     = 0;
      exp_os     = 0;
      exp_strobe = 0;
      exp_valid  = 0;
      model_ok   = 1'b1;
    end else begin : m_step
      int ln;
      bit tick;
      ln    = clamp_len(int'(i5_log2_len));
      tick  = (m_cnt >= longint'(i32_prescaler));
      m_cnt = tick ? 0 : m_cnt + 1;
      exp_strobe = m_pend;
      if (m_pend != 0) begin
        exp_os    = m_pend_avg;
        exp_valid = m_pend_valid;
      end
      m_pend = 0;
      if (ln != m_lenq) begin
        m_lenq    = ln;
        m_clear   = 32;
        m_q.delete();
        m_count   = 0;
        exp_valid = 0;
      end else if (m_clear > 0) begin
        m_clear--;
        exp_valid = 0;
      end else if (tick) begin
        m_q.push_back(int'(is_data));
        if (m_q.size() > 32) void'(m_q.pop_front());
        m_count++;
        m_pend       = 1;
        m_pend_avg   = window_avg();
        m_pend_valid = (m_count >= (1 << m_lenq)) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_strobe", int'(o_strobe), exp_strobe);
      check("model_valid",  int'(o_valid),  exp_valid);
      check("model_os",     int'(os_data),  exp_os);
    end
  end

  task automatic wait_strobe(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!o_strobe && cyc < max_cyc);
    check("strobe_timeout", int'(o_strobe), 1);
  endtask

  // Starts on the negedge where rstn was released, prescaler 500, N=8, data 1000
  task automatic run_fill_seq(input string tag);
    int cyc;
    for (int k = 1; k <= 8; k++) begin
      wait_strobe(600, cyc);
      check({tag, "_period"}, cyc, (k == 1) ? 502 : 501);
      check({tag, "_os"}, int'(os_data), 125 * k);
      check({tag, "_valid"}, int'(o_valid), (k == 8) ? 1 : 0);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int nstrobe;
    int tbl[10];
    tbl = '{100, -200, 8191, -8192, 0, 1, -1, 4321, -77, 55};

    repeat (10) @(negedge clk);
    check("reset_os", int'(os_data), 0);
    check("reset_valid", int'(o_valid), 0);
    rstn = 1'b1;
    run_fill_seq("t1");

    is_data = -14'sd1000;
    for (int k = 1; k <= 8; k++) begin
      wait_strobe(600, cyc);
      check("t2_period", cyc, 501);
      check("t2_os", int'(os_data), 1000 - 250 * k);
      check("t2_valid", int'(o_valid), 1);
    end

    // the length change lands on the same edge as the next sample tick
    repeat (499) @(negedge clk);
    i5_log2_len = 5'd5;
    @(negedge clk);
    check("t3_valid_drop", int'(o_valid), 0);
    nstrobe = 0;
    repeat (400) begin
      @(negedge clk);
      if (o_strobe) nstrobe++;
    end
    check("t3_no_strobe", nstrobe, 0);
    for (int k = 1; k <= 32; k++) begin
      wait_strobe(600, cyc);
      check("t3_valid", int'(o_valid), (k == 32) ? 1 : 0);
    end
    check("t3_os_full", int'(os_data), -1000);

    i32_prescaler = 32'd0;
    i5_log2_len   = 5'd0;
    is_data       = '0;
    repeat (40) @(negedge clk);
    for (int j = 0; j < 12; j++) begin
      if (j >= 2) check("t4_delay2", int'(os_data), tbl[j - 2]);
      if (j < 10) is_data = DATA_W'(tbl[j]);
      @(negedge clk);
    end

    is_data     = -14'sd7;
    i5_log2_len = 5'd7;
    repeat (65) @(negedge clk);
    check("t4_clamp_notyet", int'(o_valid), 0);
    @(negedge clk);
    check("t4_clamp_valid", int'(o_valid), 1);
    check("t4_clamp_os", int'(os_data), -7);

    i5_log2_len = 5'd1;
    is_data     = '0;
    repeat (40) @(negedge clk);
    is_data = 14'sd1;
    @(negedge clk);
    is_data = 14'sd2;
    @(negedge clk);
    is_data = -14'sd3;
    @(negedge clk);
`ifdef MVAVG_ROUND_EN
    check("t5_round_pos", int'(os_data), 2);
`else
    check("t5_round_pos", int'(os_data), 1);
`endif
    is_data = -14'sd2;
    @(negedge clk);
    @(negedge clk);
`ifdef MVAVG_ROUND_EN
    check("t5_round_neg", int'(os_data), -2);
`else
    check("t5_round_neg", int'(os_data), -3);
`endif

    i5_log2_len = 5'd3;
    is_data     = 14'sd1000;
    repeat (60) @(negedge clk);
    check("t6_pre_valid", int'(o_valid), 1);
    i32_prescaler = 32'd500;
    repeat (200) @(negedge clk);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("t6_async_os", int'(os_data), 0);
    check("t6_async_strobe", int'(o_strobe), 0);
    check("t6_async_valid", int'(o_valid), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    run_fill_seq("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
